// File: rtl/shift_ser_tx_nbit.sv
// Parallel-to-serial transmitter driving the ls/rs serial input and ctrl code of a
// load/store/shift register, so the receiver ends up holding the accepted word.
module shift_ser_tx_nbit #(
  parameter int n  = 4,
  parameter int CW = 3
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ld_valid,
  output logic         ld_ready,
  input  logic [n-1:0] data_in,
  input  logic         dir,
  input  logic         en,
  output logic         ser_out,
  output logic [1:0]   ctrl_out,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [CW-1:0] LAST_CNT = CW'(n - 1);

  localparam logic [1:0] CTRL_STORE = 2'b00;

  state_e         state_q, state_d;
  logic [n-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           dir_q, dir_d;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of process evaluation order.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ld_valid) begin
          shreg_d = data_in;
          dir_d   = dir;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (en) begin
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
          end else begin
            shreg_d = dir_q ? (shreg_q >> 1) : (shreg_q << 1);
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // en gates the shift code directly: a stalled cycle must present 'store' to the
  // receiver in that same cycle, otherwise it would take an extra shift.
  always_comb begin
    ld_ready = 1'b0;
    ser_out  = 1'b0;
    ctrl_out = CTRL_STORE;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      ST_IDLE:  ld_ready = 1'b1;
      ST_SHIFT: begin
        busy    = 1'b1;
        ser_out = dir_q ? shreg_q[0] : shreg_q[n-1];
        if (en) ctrl_out = {1'b1, dir_q};
      end
      ST_DONE:  done = 1'b1;
      default:  ld_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_shift_ser_tx_nbit.sv
// Bench for shift_ser_tx_nbit (n=4): word-level transfer model plus an attached
// shift-register receiver, checked every cycle, with hand-computed directed cases.
module tb_shift_ser_tx_nbit;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         clk_run = 1'b0;
  logic         clr = 1'b1;
  logic         ld_valid = 1'b0;
  logic         ld_ready;
  logic [N-1:0] data_in = '0;
  logic         dir = 1'b0;
  logic         en = 1'b1;
  logic         ser_out;
  logic [1:0]   ctrl_out;
  logic         busy;
  logic         done;

  int vectors = 0;
  int miscompares = 0;

  shift_ser_tx_nbit #(.n(N), .CW(3)) dut (
    .clk      (clk),
    .clr      (clr),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .data_in  (data_in),
    .dir      (dir),
    .en       (en),
    .ser_out  (ser_out),
    .ctrl_out (ctrl_out),
    .busy     (busy),
    .done     (done)
  );

  initial forever begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Receiver: a load/store/shift register with ls and rs both wired to ser_out.
  logic [N-1:0] rx = '0;
  always @(posedge clk) begin
    case (ctrl_out)
      2'b10:   rx <= {rx[N-2:0], ser_out};
      2'b11:   rx <= {ser_out, rx[N-1:1]};
      default: rx <= rx;
    endcase
  end

  // Word-level model: which word is in flight, how many bits it has sent, done phase.
  bit           m_busy = 0;
  bit           m_done = 0;
  logic [N-1:0] m_word = '0;
  bit           m_dir = 0;
  int           m_k = 0;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_busy = 0;
      m_done = 0;
      m_k    = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      if (en) begin
        m_k++;
        if (m_k == N) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end else if (ld_valid) begin
      m_busy = 1;
      m_word = data_in;
      m_dir  = dir;
      m_k    = 0;
    end
  end

  int           done_seen = 0;
  logic [N-1:0] rx_log[$];

  always @(negedge clk) begin
    logic       e_ready, e_busy, e_done, e_ser;
    logic [1:0] e_ctrl;
    e_ready = !m_busy && !m_done;
    e_busy  = m_busy;
    e_done  = m_done;
    e_ser   = 1'b0;
    e_ctrl  = 2'b00;
    if (m_busy) begin
      e_ser = m_dir ? m_word[m_k] : m_word[N-1-m_k];
      if (en) e_ctrl = {1'b1, m_dir};
    end
    check("ld_ready", {7'd0, ld_ready}, {7'd0, e_ready});
    check("busy",     {7'd0, busy},     {7'd0, e_busy});
    check("done",     {7'd0, done},     {7'd0, e_done});
    check("ser_out",  {7'd0, ser_out},  {7'd0, e_ser});
    check("ctrl_out", {6'd0, ctrl_out}, {6'd0, e_ctrl});
    if (done === 1'b1) done_seen++;
    if (m_done) begin
      check("rx_at_done", {4'd0, rx}, {4'd0, m_word});
      rx_log.push_back(rx);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Sends one word from IDLE; optional stall of stall_len cycles once stall_at bits
  // have gone out. Returns the serial bits in send order and the done cycle index.
  task automatic run_word(input logic [N-1:0] d, input logic dr, input int stall_at,
                          input int stall_len, output logic [N-1:0] seq, output int dcyc);
    int s;
    int st;
    s = 0;
    st = 0;
    seq = '0;
    dcyc = -1;
    ld_valid = 1'b1;
    data_in  = d;
    dir      = dr;
    en       = 1'b1;
    tick();
    ld_valid = 1'b0;
    data_in  = ~d;
    dir      = ~dr;
    for (int c = 1; c <= 40; c++) begin
      en = !(s == stall_at && st < stall_len);
      if (!en) st++;
      #1;
      if (done === 1'b1) begin
        dcyc = c;
        break;
      end
      if (ctrl_out[1] === 1'b1) begin
        seq = {seq[N-2:0], ser_out};
        s++;
      end
      tick();
    end
    en = 1'b1;
    tick();
  endtask

  logic [N-1:0] seq;
  int           dcyc;
  int           snap;
  int           accepts;
  int           acc_j[$];

  initial begin
    // 1: asynchronous reset with the clock stopped
    #3 clr = 1'b0;
    #2;
    check("rst_ld_ready", {7'd0, ld_ready}, 8'd1);
    check("rst_ctrl",     {6'd0, ctrl_out}, 8'd0);
    check("rst_ser",      {7'd0, ser_out},  8'd0);
    check("rst_busy",     {7'd0, busy},     8'd0);
    check("rst_done",     {7'd0, done},     8'd0);
    clk_run = 1'b1;
    tick();
    tick();
    clr = 1'b1;
    tick();

    // 2: MSB first
    run_word(4'b1011, 1'b0, -1, 0, seq, dcyc);
    check("t2_seq",  {4'd0, seq}, 8'b1011);
    check("t2_done", 8'(dcyc), 8'd5);
    check("t2_rx",   {4'd0, rx},  8'b1011);

    // 3: LSB first, bits go out as 1,1,0,1
    rx = '0;
    run_word(4'b1011, 1'b1, -1, 0, seq, dcyc);
    check("t3_seq",  {4'd0, seq}, 8'b1101);
    check("t3_done", 8'(dcyc), 8'd5);
    check("t3_rx",   {4'd0, rx},  8'b1011);

    // 4: two stall cycles after the second shift
    rx = '0;
    run_word(4'b1011, 1'b0, 2, 2, seq, dcyc);
    check("t4_seq",  {4'd0, seq}, 8'b1011);
    check("t4_done", 8'(dcyc), 8'd7);
    check("t4_rx",   {4'd0, rx},  8'b1011);

    // 5: abort after two shifts, receiver keeps its partial value 1011->0111->1110
    ld_valid = 1'b1;
    data_in  = 4'b1011;
    dir      = 1'b0;
    en       = 1'b1;
    tick();
    ld_valid = 1'b0;
    tick();
    tick();
    snap = done_seen;
    #1 clr = 1'b0;
    #1;
    check("abort_ld_ready", {7'd0, ld_ready}, 8'd1);
    check("abort_ctrl",     {6'd0, ctrl_out}, 8'd0);
    check("abort_busy",     {7'd0, busy},     8'd0);
    check("abort_ser",      {7'd0, ser_out},  8'd0);
    check("abort_rx",       {4'd0, rx},       8'b1110);
    tick();
    tick();
    clr = 1'b1;
    tick();
    tick();
    check("abort_no_done", 8'(done_seen - snap), 8'd0);
    run_word(4'b0110, 1'b0, -1, 0, seq, dcyc);
    check("t5_seq", {4'd0, seq}, 8'b0110);
    check("t5_rx",  {4'd0, rx},  8'b0110);

    // 6: ld_valid held high, data and dir changing every cycle
    rx_log.delete();
    accepts = 0;
    for (int j = 0; j < 24; j++) begin
      logic [7:0] jv;
      jv       = 8'(j);
      data_in  = 4'(j * 5 + 3);
      dir      = jv[1];
      ld_valid = 1'b1;
      en       = 1'b1;
      #1;
      if (ld_ready === 1'b1) begin
        accepts++;
        acc_j.push_back(j);
      end
      tick();
    end
    ld_valid = 1'b0;
    tick();
    tick();
    check("t6_accepts", 8'(accepts), 8'd4);
    if (acc_j.size() == 4) begin
      check("t6_acc0", 8'(acc_j[0]), 8'd0);
      check("t6_acc1", 8'(acc_j[1]), 8'd6);
      check("t6_acc2", 8'(acc_j[2]), 8'd12);
      check("t6_acc3", 8'(acc_j[3]), 8'd18);
    end
    check("t6_words", 8'(rx_log.size()), 8'd4);
    if (rx_log.size() == 4) begin
      check("t6_rx0", {4'd0, rx_log[0]}, 8'h3);
      check("t6_rx1", {4'd0, rx_log[1]}, 8'h1);
      check("t6_rx2", {4'd0, rx_log[2]}, 8'hF);
      check("t6_rx3", {4'd0, rx_log[3]}, 8'hD);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
